// File: rtl/i2c_master_writer.sv
// ============================================================================
//  Module   : i2c_master_writer
//  Purpose  : I2C master write engine (START, addr+W, N data bytes, STOP)
//             with ACK sampling and abort on NACK; open-drain oe outputs.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_master_writer #(
   parameter int DIV   = 250,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic [6:0]       i_addr,
   input  logic [LEN_W-1:0] i_len,
   input  logic [7:0]       i_wr_data,
   output logic             o_data_req,
   input  logic             i_sda_in,
   output logic             o_scl_oe,
   output logic             o_sda_oe,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_nack
);

   localparam int QW = $clog2(DIV);
   localparam logic [QW-1:0] c_QLAST = QW'(DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_BIT   = 3'd2,
      S_ACK   = 3'd3,
      S_STOP  = 3'd4
   } state_t;

   state_t            r_state,  w_state;
   logic [QW-1:0]     r_qcnt,   w_qcnt;
   logic [1:0]        r_qi,     w_qi;
   logic [2:0]        r_bitcnt, w_bitcnt;
   logic [7:0]        r_shift,  w_shift;
   logic [LEN_W-1:0]  r_remain, w_remain;
   logic              r_ack,    w_ack;
   logic              w_nack, w_busy, w_req, w_done, w_scl, w_sda;
   logic              w_tick;

   assign w_tick = (r_state != S_IDLE) && (r_qcnt == c_QLAST);

   // Line levels for a given state/quarter; returns {scl_oe, sda_oe}.
   function automatic logic [1:0] f_lines(input state_t st, input logic [1:0] q, input logic b);
      logic [1:0] v;
      v = 2'b00;
      case (st)
         S_START: v = (q == 2'd0) ? 2'b00 : (q == 2'd3) ? 2'b11 : 2'b01;
         S_BIT:   v = {(q == 2'd0) || (q == 2'd3), ~b};
         S_ACK:   v = {(q == 2'd0) || (q == 2'd3), 1'b0};
         S_STOP:  v = (q == 2'd0) ? 2'b11 : (q == 2'd1) ? 2'b01 : 2'b00;
         default: v = 2'b00;
      endcase
      return v;
   endfunction

   always_comb begin
      w_state  = r_state;
      w_qcnt   = r_qcnt;
      w_qi     = r_qi;
      w_bitcnt = r_bitcnt;
      w_shift  = r_shift;
      w_remain = r_remain;
      w_ack    = r_ack;
      w_nack   = o_nack;
      w_busy   = o_busy;
      w_req    = 1'b0;
      w_done   = 1'b0;
      // The data byte arrives in the data_req cycle, first cycle of BIT q0.
      if (o_data_req) w_shift = i_wr_data;
      if (r_state == S_IDLE) begin
         w_qcnt = '0;
         w_qi   = 2'd0;
         if (i_start) begin
            w_state  = S_START;
            w_shift  = {i_addr, 1'b0};
            w_remain = i_len;
            w_nack   = 1'b0;
            w_busy   = 1'b1;
         end
      end else begin
         w_qcnt = w_tick ? '0 : r_qcnt + 1'b1;
         if (w_tick) begin
            w_qi = r_qi + 2'd1;
            case (r_state)
               S_START: if (r_qi == 2'd3) begin
                  w_state  = S_BIT;
                  w_bitcnt = 3'd0;
               end
               S_BIT: if (r_qi == 2'd3) begin
                  w_shift  = {r_shift[6:0], 1'b0};
                  w_bitcnt = r_bitcnt + 3'd1;
                  if (r_bitcnt == 3'd7) w_state = S_ACK;
               end
               S_ACK: begin
                  if (r_qi == 2'd1) w_ack = i_sda_in;
                  if (r_qi == 2'd3) begin
                     if (r_ack) begin
                        w_nack  = 1'b1;
                        w_state = S_STOP;
                     end else if (r_remain != '0) begin
                        w_req    = 1'b1;
                        w_remain = r_remain - 1'b1;
                        w_bitcnt = 3'd0;
                        w_state  = S_BIT;
                     end else begin
                        w_state = S_STOP;
                     end
                  end
               end
               S_STOP: if (r_qi == 2'd3) begin
                  w_state = S_IDLE;
                  w_busy  = 1'b0;
                  w_done  = 1'b1;
               end
               default: w_state = S_IDLE;
            endcase
         end
      end
      {w_scl, w_sda} = f_lines(w_state, w_qi, w_shift[7]);
      // SDA stays released until the fresh byte is loaded.
      if (w_req) w_sda = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_qcnt     <= '0;
         r_qi       <= 2'd0;
         r_bitcnt   <= 3'd0;
         r_shift    <= 8'd0;
         r_remain   <= '0;
         r_ack      <= 1'b0;
         o_nack     <= 1'b0;
         o_busy     <= 1'b0;
         o_data_req <= 1'b0;
         o_done     <= 1'b0;
         o_scl_oe   <= 1'b0;
         o_sda_oe   <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_qcnt     <= w_qcnt;
         r_qi       <= w_qi;
         r_bitcnt   <= w_bitcnt;
         r_shift    <= w_shift;
         r_remain   <= w_remain;
         r_ack      <= w_ack;
         o_nack     <= w_nack;
         o_busy     <= w_busy;
         o_data_req <= w_req;
         o_done     <= w_done;
         o_scl_oe   <= w_scl;
         o_sda_oe   <= w_sda;
      end
   end

endmodule

`default_nettype wire

// File: doc/i2c_master_writer.md
# i2c_master_writer

Parametrised I2C master write engine: generates a START condition, the 7-bit address with the write bit, a programmable number of data bytes and a STOP condition on an open-drain SCL/SDA pair. It samples slave ACK and aborts on NACK. Its bit-timing divider runs only while a transfer is active, for low-power operation. It sits between a host request interface and the I2C pad cells and replaces the fixed single-bit write FSM with a real byte-shifting, ACK-checking master.

## Interface
Parameters:
- DIV, default 250: clk cycles per quarter SCL period; legal range ≥ 2. SCL period is 4·DIV.
- LEN_W, default 4: width of the data-byte count.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  transfer request; accepted only in a cycle where busy=0.
- addr  in  7  slave address; latched when start is accepted.
- len  in  LEN_W  number of data bytes after the address; 0 means address only. Latched when start is accepted.
- wr_data  in  8  next data byte; sampled in the cycle data_req=1.
- data_req  out  1  one-cycle pulse; wr_data is consumed this cycle.
- sda_in  in  1  SDA line level from the pad.
- scl_oe  out  1  1 drives SCL low; 0 releases it (pulled high).
- sda_oe  out  1  1 drives SDA low; 0 releases it.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse when a transfer ends (normally or via NACK).
- nack  out  1  set when the slave NACKs; held until the next accepted start.

## Operation
- Reset values:
  - scl_oe=0, sda_oe=0.
  - busy=0, done=0, nack=0, data_req=0.
  - State IDLE; quarter counter 0; bit counter 0.
- Quarter counter: counts 0..DIV-1 and produces a tick at DIV-1. It is held at 0 in IDLE, so no toggling logic runs.
- Each non-IDLE state spans four quarters, q0..q3. The quarter index advances on each tick.
- Accepting start (IDLE, start=1):
  - Latch addr and len.
  - Shift register ← {addr, 1'b0}.
  - Clear nack, set busy, go to START.
- START:
  - q0: both lines released.
  - q1–q2: sda_oe=1 (START condition).
  - q3: scl_oe=1, sda_oe=1.
  - Then go to BIT with bit counter 0.
- BIT:
  - sda_oe = ~shift[7] for all four quarters.
  - scl_oe=1 in q0 and q3; scl_oe=0 in q1–q2.
  - At the end of q3: shift left and increment the bit counter. After 8 bits go to ACK.
- ACK:
  - sda_oe=0 throughout.
  - scl_oe=1 in q0 and q3; 0 in q1–q2.
  - sda_in is sampled on the tick ending q1.
  - At the end of q3:
    - Sampled 1: set nack, go to STOP.
    - Sampled 0 and data bytes remain: pulse data_req, load shift ← wr_data, decrement the remaining count, go to BIT.
    - Otherwise: go to STOP.
- STOP:
  - q0: scl_oe=1, sda_oe=1.
  - q1: scl_oe=0, sda_oe=1.
  - q2–q3: both released (STOP condition).
  - At the end of q3: go to IDLE, busy←0, done←1 for one cycle.
- start while busy=1 is ignored; it is not queued.
- nack never clears mid-transfer.

## Timing
- All outputs are registered.
- If start is accepted in cycle T, the START q0 drive appears in cycle T+1.
- Total quarters Q = 4·(2 + 9·(len+1)) on a fully ACKed transfer.
- done=1 and busy=0 both occur in cycle T+1+Q·DIV.
- On a NACK after byte k (0 = address byte), Q = 4·(2 + 9·(k+1)).
- data_req fires in the cycle after the final tick of the preceding ACK state. It pulses exactly min(len, bytes ACKed) times.
- Data changes only while SCL is low (q0 of BIT/ACK). SDA transitions with SCL high happen only in START q1 and STOP q2.
- Reset mid-transfer: on the next clk edge both oe outputs go to 0 and busy goes to 0. No done is generated, nack is cleared and the counters are zeroed.
- Clock stretching and arbitration are not supported.

## Test plan
- DIV=4, addr=0x50, len=1, wr_data=0xA5, sda_in=0 in ACK slots:
  - SDA sampled at SCL rise reads 1010000,0 then 10100101.
  - data_req pulses once; nack=0.
  - done occurs at T+321.
- DIV=4, addr=0x3C, len=2, sda_in=1 in the address ACK slot:
  - STOP follows immediately; nack=1; data_req never pulses.
  - done occurs at T+177.
- DIV=4, len=0, ACKed:
  - Address-only transfer; done at T+177; nack=0; data_req never pulses.
- DIV=4, len=3, bytes 0x11/0x22/0x33, NACK on the second data byte:
  - data_req pulses twice; nack=1.
  - done at T+1+4·4·(2+27) = T+465.
- Start pulsed while busy: ignored, and the transfer completes unchanged.
- Reset asserted mid-byte: scl_oe=sda_oe=busy=0 on the next cycle, with no done pulse.
- In IDLE for 1000 cycles: scl_oe=sda_oe=0 and the quarter counter stays at 0.
